// File: rtl/risc_pkg.sv
// Shared types for the VeriRISC accumulator core: opcodes, sequencer states
// and the retirement rule used by the optional instruction counter.
package risc_pkg;

    localparam int unsigned OPCODE_WIDTH = 3;
    localparam int unsigned RETIRE_WIDTH = 32;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_OPREAD  = 3'd2,
        ST_OPWRITE = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    // Opcodes that complete in DECODE without touching the bus.
    function automatic logic retires_in_decode(input opcode_e op);
        return (op == OP_HLT) || (op == OP_SKZ) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational accumulator ALU: ADD wraps modulo 2^DATA_WIDTH, AND/XOR are
// bitwise, LDA passes the operand through.
module risc_alu
    import risc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]   acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    output logic [DATA_WIDTH-1:0]   result
);

    always_comb begin
        result = acc;
        case (opcode_e'(op))
            OP_ADD:  result = acc + operand;
            OP_AND:  result = acc & operand;
            OP_XOR:  result = acc ^ operand;
            OP_LDA:  result = operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/risc_core.sv
// VeriRISC accumulator core with a state-machine sequencer and an external
// ready-handshaked memory bus. Define RISC_RETIRE_CNT_EN to add the retired counter.
module risc_core
    import risc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  halt,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  zero
`ifdef RISC_RETIRE_CNT_EN
    ,
    output logic [RETIRE_WIDTH-1:0] retired
`endif
);

    localparam int unsigned IR_WIDTH = ADDR_WIDTH + OPCODE_WIDTH;

    if (ADDR_WIDTH + OPCODE_WIDTH > DATA_WIDTH) begin : g_width_check
        $fatal(1, "risc_core: DATA_WIDTH must be at least ADDR_WIDTH+3");
    end

    state_e                state;
    logic [IR_WIDTH-1:0]   ir;
    opcode_e               ir_op;
    logic [ADDR_WIDTH-1:0] ir_addr;
    logic [DATA_WIDTH-1:0] alu_result;

    // Only opcode and operand address are kept; higher instruction bits are ignored.
    assign ir_op   = opcode_e'(ir[IR_WIDTH-1:ADDR_WIDTH]);
    assign ir_addr = ir[ADDR_WIDTH-1:0];

    risc_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op      (ir[IR_WIDTH-1:ADDR_WIDTH]),
        .acc     (acc),
        .operand (mem_rdata),
        .result  (alu_result)
    );

    // Sequencer: state, PC, IR and accumulator advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= ADDR_WIDTH'(RESET_PC);
            acc   <= '0;
            ir    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[IR_WIDTH-1:0];
                        pc    <= pc + ADDR_WIDTH'(1);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (ir_op)
                        OP_HLT: state <= ST_HALT;
                        OP_SKZ: begin
                            if (acc == '0) begin
                                pc <= pc + ADDR_WIDTH'(1);
                            end
                            state <= ST_FETCH;
                        end
                        OP_JMP: begin
                            pc    <= ir_addr;
                            state <= ST_FETCH;
                        end
                        OP_STO:  state <= ST_OPWRITE;
                        default: state <= ST_OPREAD;
                    endcase
                end
                ST_OPREAD: begin
                    if (mem_ready) begin
                        acc   <= alu_result;
                        state <= ST_FETCH;
                    end
                end
                ST_OPWRITE: begin
                    if (mem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Bus and halt decode from state; held low while reset is asserted so an
    // in-flight request is abandoned in the reset cycle itself.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halt     = 1'b0;
        mem_addr = pc;
        if (!rst) begin
            case (state)
                ST_FETCH: mem_rd = 1'b1;
                ST_OPREAD: begin
                    mem_rd   = 1'b1;
                    mem_addr = ir_addr;
                end
                ST_OPWRITE: begin
                    mem_wr   = 1'b1;
                    mem_addr = ir_addr;
                end
                ST_HALT:  halt = 1'b1;
                default:  mem_rd = 1'b0;
            endcase
        end
    end

    assign mem_wdata = acc;
    assign zero      = (acc == '0);

`ifdef RISC_RETIRE_CNT_EN
    logic retire_c;

    assign retire_c = ((state == ST_DECODE) && retires_in_decode(ir_op)) ||
                      (((state == ST_OPREAD) || (state == ST_OPWRITE)) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + RETIRE_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/risc_core.md
# risc_core

Parametrised VeriRISC processor core: 3-bit-opcode accumulator machine (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) with configurable data and address widths. Replaces the fixed eight-phase controller and internal memory with a state-machine sequencer and an external single-port memory bus with a ready handshake, so instruction and operand accesses may take wait states. Adds a resume input to leave halt. Sits between the system top and a shared program/data memory.

## Interface
- DATA_WIDTH, 8, accumulator and memory word width; must be >= ADDR_WIDTH+3
- ADDR_WIDTH, 5, PC and memory address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- resume  in  1  single-cycle pulse; leaves HALT
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_wdata  out  DATA_WIDTH  write data (accumulator)
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1
- mem_ready  in  1  completes the pending request this cycle
- halt  out  1  core is in HALT
- acc  out  DATA_WIDTH  accumulator (debug)
- pc  out  ADDR_WIDTH  program counter (debug)
- zero  out  1  acc == 0
- retired  out  32  instructions retired (only with RISC_RETIRE_CNT_EN)

## Operation
- States: FETCH, DECODE, OPREAD, OPWRITE, HALT. Reset: state FETCH, pc=RESET_PC, acc=0, ir=0, halt=0, mem_rd=mem_wr=0 in the reset cycle, retired=0.
- Instruction word: opcode = word[ADDR_WIDTH+2:ADDR_WIDTH], operand address = word[ADDR_WIDTH-1:0]; bits above ignored.
- FETCH: mem_rd=1, mem_addr=pc. On mem_ready: ir<=mem_rdata, pc<=pc+1, -> DECODE. Else hold.
- DECODE (no bus activity): HLT -> HALT; SKZ -> pc<=pc+1 if acc==0, -> FETCH; JMP -> pc<=ir_addr, -> FETCH; ADD/AND/XOR/LDA -> OPREAD; STO -> OPWRITE.
- OPREAD: mem_rd=1, mem_addr=ir_addr. On mem_ready: acc<=ALU(acc, mem_rdata), -> FETCH.
- OPWRITE: mem_wr=1, mem_addr=ir_addr, mem_wdata=acc. On mem_ready -> FETCH.
- HALT: halt=1, no bus activity. resume=1 -> FETCH (pc already past HLT). resume ignored in other states.
- ALU: ADD acc+b modulo 2^DATA_WIDTH, carry discarded; AND, XOR bitwise; LDA b.
- PC wraps 2^ADDR_WIDTH-1 -> 0 on increment and on SKZ skip.
- mem_rd and mem_wr never both 1. Request held with stable mem_addr/mem_wdata until mem_ready sampled 1. mem_ready outside a request ignored.
- mem_wdata drives acc at all times; meaningful only with mem_wr.

## Timing
- Bus outputs and halt are Moore outputs decoded from registered state.
- Zero-wait memory (mem_ready=1): SKZ/JMP 2 cycles, ALU ops and STO 3 cycles, HLT 2 cycles to halt=1.
- Each wait cycle (mem_ready=0) adds one cycle to FETCH/OPREAD/OPWRITE.
- acc, zero update the cycle after the OPREAD handshake; pc after FETCH/DECODE.
- First mem_rd: first cycle after rst deasserts.
- rst mid-access: request abandoned; mem_rd/mem_wr low during the reset cycle; any mem_ready on that edge ignored.
- rst and resume together: rst wins.
- resume in the cycle halt rises is accepted (state HALT); mem_rd asserts next cycle.

## Configuration
- RISC_RETIRE_CNT_EN defined: retired port present; 32-bit counter increments by 1 on DECODE exit for SKZ/JMP/HLT and on the handshake cycle of OPREAD/OPWRITE. Wraps at 2^32. Cleared by rst.
- Not defined: no port, no counter logic; otherwise identical.

## Structure
- Package risc_pkg: opcode enum (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7), sequencer state enum.
- Sub-module risc_alu (combinational, DATA_WIDTH-parametrised): opcode, acc, operand -> result.
- Elaboration check: ADDR_WIDTH+3 > DATA_WIDTH is a fatal error.

## Test plan
- Defaults, zero-wait memory, program LDA 10; ADD 11; STO 12; HLT with mem[10]=3, mem[11]=4 -> mem[12]=7, halt=1 after 11 cycles, pc=4.
- SKZ with acc=0 at pc=2 -> next fetch address 4; with acc=5 -> 3.
- Random 0-3 wait cycles on every request -> same final memory as zero-wait; mem_addr/mem_rd stable while mem_ready=0.
- JMP 31 at pc=31 (ADDR_WIDTH=5) -> pc=31 looping; FETCH increment from 31 -> 0; ADD 0xFF+0x02 -> acc=0x01.
- rst asserted in OPWRITE with mem_ready=0 -> no write completes, pc=RESET_PC, acc=0, mem_wr=0 during reset; HLT then resume -> fetch resumes at HLT address+1.
- DATA_WIDTH=16, ADDR_WIDTH=10, RISC_RETIRE_CNT_EN: 5-instruction program ending in HLT -> retired=5; without macro, same acc/mem result.
